// File: rtl/pcs_rx_sync_monitor.sv
// pcs_rx_sync_monitor
// 10GBASE-R receive block-sync and bit-error monitor. It sits between the RX
// gearbox and the descrambler. It hunts for 66b block alignment using the
// 2-bit sync header and asks the gearbox to slip on a bad header. It holds
// block lock with a programmable bad-header tolerance, and runs a windowed
// hi_ber detector together with saturating management counters.
//
// Ports
//   i_clk           RX user clock (single domain)
//   i_reset_n       async active-low reset; released synchronously inside
//   i_header        2-bit sync header from the gearbox
//   i_header_valid  i_header carries a new block header this cycle
//   i_block_error   decoder flagged this block; qualified by i_header_valid
//   i_clear_counts  synchronous clear of o_ber_count / o_err_count
//   o_slip          one-cycle gearbox slip request
//   o_block_lock    block lock achieved
//   o_hi_ber        high bit-error-rate condition
//   o_ber_count     saturating invalid-header count while locked
//   o_err_count     saturating errored-block count while locked
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_HUNT      | counting consecutive valid headers toward lock
// ST_SLIP_WAIT | gearbox settling after a slip; headers ignored
// ST_LOCKED    | aligned; bad headers tallied per LOCK_CNT-header window

module pcs_rx_sync_monitor #(
    parameter int LOCK_CNT      = 64,
    parameter int BAD_LIMIT     = 16,
    parameter int SLIP_WAIT     = 32,
    parameter int BER_WINDOW    = 40283,
    parameter int BER_LIMIT     = 16,
    parameter int ERR_CNT_WIDTH = 22
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [1:0]               i_header,
    input  logic                     i_header_valid,
    input  logic                     i_block_error,
    input  logic                     i_clear_counts,
    output logic                     o_slip,
    output logic                     o_block_lock,
    output logic                     o_hi_ber,
    output logic [5:0]               o_ber_count,
    output logic [ERR_CNT_WIDTH-1:0] o_err_count
);

    localparam int SH_W  = $clog2(LOCK_CNT + 1);
    localparam int BAD_W = $clog2(BAD_LIMIT + 1);
    localparam int SW_W  = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
    localparam int BT_W  = (BER_WINDOW > 1) ? $clog2(BER_WINDOW) : 1;
    localparam int BW_W  = $clog2(BER_LIMIT + 1);

    localparam logic [SH_W-1:0]  C_LOCK_M1   = SH_W'(LOCK_CNT - 1);
    localparam logic [BAD_W-1:0] C_BAD_M1    = BAD_W'(BAD_LIMIT - 1);
    localparam logic [SW_W-1:0]  C_SLIP_LOAD = SW_W'(SLIP_WAIT - 1);
    localparam logic [BT_W-1:0]  C_BT_LOAD   = BT_W'(BER_WINDOW - 1);
    localparam logic [BW_W-1:0]  C_BER_LIM   = BW_W'(BER_LIMIT);

    typedef enum logic [1:0] {
        ST_HUNT      = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } state_t;

    // Reset synchronizer: assertion reaches every flop at once, release is
    // aligned to i_clk so no flop sees a partial recovery edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SH_W-1:0]    r_sh_cnt;
    logic [SH_W-1:0]    w_sh_cnt_nxt;
    logic [SH_W-1:0]    r_win_cnt;
    logic [SH_W-1:0]    w_win_cnt_nxt;
    logic [BAD_W-1:0]   r_bad_cnt;
    logic [BAD_W-1:0]   w_bad_cnt_nxt;
    logic [SW_W-1:0]    r_slip_tmr;
    logic [SW_W-1:0]    w_slip_tmr_nxt;
    logic               r_slip;
    logic               w_slip_nxt;
    logic               r_block_lock;
    logic               w_lock_nxt;
    logic               w_lose_lock;

    logic               w_hdr_bad;
    logic               w_hdr_good;

    assign w_hdr_bad  = i_header_valid & ~(i_header[1] ^ i_header[0]);
    assign w_hdr_good = i_header_valid &  (i_header[1] ^ i_header[0]);

    always_comb begin
        w_state_nxt    = r_state;
        w_sh_cnt_nxt   = r_sh_cnt;
        w_win_cnt_nxt  = r_win_cnt;
        w_bad_cnt_nxt  = r_bad_cnt;
        w_slip_tmr_nxt = r_slip_tmr;
        w_slip_nxt     = 1'b0;
        w_lock_nxt     = r_block_lock;
        w_lose_lock    = 1'b0;

        case (r_state)
            ST_HUNT: begin
                if (w_hdr_bad) begin
                    w_slip_nxt     = 1'b1;
                    w_sh_cnt_nxt   = '0;
                    w_slip_tmr_nxt = C_SLIP_LOAD;
                    w_state_nxt    = ST_SLIP_WAIT;
                end else if (w_hdr_good) begin
                    if (r_sh_cnt == C_LOCK_M1) begin
                        w_state_nxt   = ST_LOCKED;
                        w_lock_nxt    = 1'b1;
                        w_sh_cnt_nxt  = '0;
                        w_win_cnt_nxt = '0;
                        w_bad_cnt_nxt = '0;
                    end else begin
                        w_sh_cnt_nxt = r_sh_cnt + 1'b1;
                    end
                end
            end

            ST_SLIP_WAIT: begin
                if (r_slip_tmr == '0) begin
                    w_state_nxt  = ST_HUNT;
                    w_sh_cnt_nxt = '0;
                end else begin
                    w_slip_tmr_nxt = r_slip_tmr - 1'b1;
                end
            end

            ST_LOCKED: begin
                if (i_header_valid) begin
                    // Loss of lock is tested first so a BAD_LIMIT-th bad
                    // header that also closes the window still drops lock.
                    if (w_hdr_bad && (r_bad_cnt == C_BAD_M1)) begin
                        w_lose_lock    = 1'b1;
                        w_lock_nxt     = 1'b0;
                        w_slip_nxt     = 1'b1;
                        w_slip_tmr_nxt = C_SLIP_LOAD;
                        w_win_cnt_nxt  = '0;
                        w_bad_cnt_nxt  = '0;
                        w_state_nxt    = ST_SLIP_WAIT;
                    end else if (r_win_cnt == C_LOCK_M1) begin
                        w_win_cnt_nxt = '0;
                        w_bad_cnt_nxt = '0;
                    end else begin
                        w_win_cnt_nxt = r_win_cnt + 1'b1;
                        w_bad_cnt_nxt = r_bad_cnt + BAD_W'(w_hdr_bad);
                    end
                end
            end

            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= ST_HUNT;
            r_sh_cnt     <= '0;
            r_win_cnt    <= '0;
            r_bad_cnt    <= '0;
            r_slip_tmr   <= '0;
            r_slip       <= 1'b0;
            r_block_lock <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sh_cnt     <= w_sh_cnt_nxt;
            r_win_cnt    <= w_win_cnt_nxt;
            r_bad_cnt    <= w_bad_cnt_nxt;
            r_slip_tmr   <= w_slip_tmr_nxt;
            r_slip       <= w_slip_nxt;
            r_block_lock <= w_lock_nxt;
        end
    end

    // hi_ber monitor. The window timer counts down from BER_WINDOW-1 and
    // wraps at zero; it idles at the load value whenever lock is absent, so
    // the first locked cycle is the first cycle of a fresh window.
    logic [BT_W-1:0] r_ber_tmr;
    logic [BW_W-1:0] r_ber_win;
    logic            r_hi_ber;
    logic            w_ber_wrap;
    logic [BW_W-1:0] w_ber_win_base;
    logic [BW_W-1:0] w_ber_win_nxt;
    logic            w_hi_ber_nxt;

    always_comb begin
        w_ber_wrap     = (r_ber_tmr == '0);
        // A bad header on the wrap cycle belongs to the new window.
        w_ber_win_base = w_ber_wrap ? '0 : r_ber_win;
        w_ber_win_nxt  = w_ber_win_base;
        if (w_hdr_bad && (w_ber_win_base != C_BER_LIM)) begin
            w_ber_win_nxt = w_ber_win_base + 1'b1;
        end
        w_hi_ber_nxt = r_hi_ber;
        if (w_ber_wrap && (r_ber_win != C_BER_LIM)) begin
            w_hi_ber_nxt = 1'b0;
        end
        if (w_ber_win_nxt == C_BER_LIM) begin
            w_hi_ber_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ber_tmr <= C_BT_LOAD;
            r_ber_win <= '0;
            r_hi_ber  <= 1'b0;
        end else if ((r_state != ST_LOCKED) || w_lose_lock) begin
            r_ber_tmr <= C_BT_LOAD;
            r_ber_win <= '0;
            r_hi_ber  <= 1'b0;
        end else begin
            r_ber_tmr <= w_ber_wrap ? C_BT_LOAD : (r_ber_tmr - 1'b1);
            r_ber_win <= w_ber_win_nxt;
            r_hi_ber  <= w_hi_ber_nxt;
        end
    end

    // Management counters survive lock loss; only reset or clear zero them.
    logic [5:0]               r_ber_count;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ber_count <= '0;
            r_err_count <= '0;
        end else if (i_clear_counts) begin
            r_ber_count <= '0;
            r_err_count <= '0;
        end else if (r_state == ST_LOCKED) begin
            if (w_hdr_bad && (r_ber_count != '1)) begin
                r_ber_count <= r_ber_count + 1'b1;
            end
            if (i_header_valid && i_block_error && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign o_slip       = r_slip;
    assign o_block_lock = r_block_lock;
    assign o_hi_ber     = r_hi_ber;
    assign o_ber_count  = r_ber_count;
    assign o_err_count  = r_err_count;

endmodule
